// File: rtl/rv_pipe_pkg.sv
// Shared pipeline types for the fetch front end.
// Holds XLEN, the canonical NOP and the fetch FSM state encoding.
package rv_pipe_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_pkt_t;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry hold buffer that parks a fetch response
// while IF/ID is stalled.
module if_skid_buf
  import rv_pipe_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic       clear,
  input  fetch_pkt_t din,
  output fetch_pkt_t dout,
  output logic       full
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full <= 1'b0;
      dout <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (push) begin
      full <= 1'b1;
      dout <= din;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: single-outstanding fetch FSM feeding IF/ID.
// Define IF_STAGE_PERF_EN to add stall_cnt/flush_cnt outputs.
module if_stage
  import rv_pipe_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pc_write,
  input  logic            if_id_write,
  input  logic            flush,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_instr,
  output logic            if_id_valid
`ifdef IF_STAGE_PERF_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     flush_cnt
`endif
);

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] req_pc;
  logic [XLEN-1:0] redir;
  logic            kill;
  logic            fire;
  logic            resp_ok;
  logic            push;
  logic            pop;
  logic            hold_full;
  fetch_pkt_t      hold_in;
  fetch_pkt_t      hold_pkt;

  assign redir     = redirect_pc & ~32'h3;
  assign imem_req  = (state == REQ) && pc_write && !hold_full;
  assign imem_addr = pc;
  assign fire      = imem_req && imem_gnt;
  // A response is usable only if no redirect killed it.
  assign resp_ok   = (state == WAIT) && imem_rvalid
                     && !kill && !flush;
  assign push      = resp_ok && !if_id_write;
  assign pop       = hold_full && if_id_write && !flush;
  assign hold_in   = '{pc: req_pc, instr: imem_rdata};

  if_skid_buf u_hold (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .clear (flush),
    .din   (hold_in),
    .dout  (hold_pkt),
    .full  (hold_full)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      req_pc <= '0;
      kill   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (fire) begin
            state  <= WAIT;
            req_pc <= pc;
            kill   <= flush;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            state <= REQ;
            kill  <= 1'b0;
          end else if (flush) begin
            kill <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      if (flush) begin
        pc <= redir;
      end else if (fire) begin
        pc <= pc + 32'd4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if_id_valid <= 1'b0;
      if_id_pc    <= '0;
      if_id_instr <= NOP;
    end else if (flush) begin
      if_id_valid <= 1'b0;
      if_id_instr <= NOP;
    end else if (if_id_write) begin
      if (hold_full) begin
        if_id_valid <= 1'b1;
        if_id_pc    <= hold_pkt.pc;
        if_id_instr <= hold_pkt.instr;
      end else if (resp_ok) begin
        if_id_valid <= 1'b1;
        if_id_pc    <= req_pc;
        if_id_instr <= imem_rdata;
      end else begin
        if_id_valid <= 1'b0;
        if_id_instr <= NOP;
      end
    end
  end

`ifdef IF_STAGE_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_write) stall_cnt <= stall_cnt + 32'd1;
      if (flush) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: directed phases push expected
// fetch addresses and IF/ID contents; a monitor pops and compares.
module tb_if_stage;
  import rv_pipe_pkg::*;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pc_write = 1'b1;
  logic        if_id_write = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
`ifdef IF_STAGE_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  int tests = 0;
  int fails = 0;
  int lat = 1;
  int cnt = 0;
  logic [31:0] pend = '0;
  logic [31:0] exp_addr[$];
  logic [63:0] exp_ifid[$];

  assign imem_gnt = imem_req;
  always #5 clk = ~clk;

  if_stage #(.RESET_PC(RPC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_write    (pc_write),
    .if_id_write (if_id_write),
    .flush       (flush),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_id_pc    (if_id_pc),
    .if_id_instr (if_id_instr),
    .if_id_valid (if_id_valid)
`ifdef IF_STAGE_PERF_EN
    ,
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
`endif
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hDEAD_0003;
  endfunction

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  task automatic expect_fetch(input logic [31:0] a);
    exp_addr.push_back(a);
  endtask

  task automatic expect_ifid(input logic [31:0] a);
    exp_ifid.push_back({a, mem(a)});
  endtask

  task automatic park();
    repeat (3) @(posedge clk);
  endtask

  // Memory: response lat cycles after grant, even across reset.
  always @(negedge clk) begin
    imem_rvalid = 1'b0;
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem(pend);
      end
    end
    if (imem_req && imem_gnt) begin
      pend = imem_addr;
      cnt  = lat;
    end
  end

  always @(negedge clk) begin
    logic [63:0] e;
    if (imem_req && imem_gnt) begin
      if (exp_addr.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL imem_addr: got %h want none", imem_addr);
      end else begin
        chk("imem_addr", imem_addr, exp_addr.pop_front());
      end
    end
    if (rst_n && if_id_valid && if_id_write && !flush) begin
      if (exp_ifid.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL if_id: got pc %h want none", if_id_pc);
      end else begin
        e = exp_ifid.pop_front();
        chk("if_id_pc", if_id_pc, e[63:32]);
        chk("if_id_instr", if_id_instr, e[31:0]);
      end
    end
    if (rst_n && !if_id_valid)
      chk("nop_invalid", if_id_instr, NOP);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_valid", 32'(if_id_valid), 0);
    chk("rst_pc", if_id_pc, 0);
    chk("rst_instr", if_id_instr, NOP);

    // Reset release and back-to-back fetches
    expect_fetch(32'h100); expect_fetch(32'h104); expect_fetch(32'h108);
    expect_ifid(32'h100); expect_ifid(32'h104); expect_ifid(32'h108);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("first_valid", 32'(if_id_valid), 1);
    chk("first_pc", if_id_pc, 32'h100);
    repeat (3) @(posedge clk);
    #1 pc_write = 1'b0;
    park();

    // IF/ID stall while a response arrives
    expect_fetch(32'h10C); expect_fetch(32'h110);
    expect_ifid(32'h10C); expect_ifid(32'h110);
    @(posedge clk); #1 pc_write = 1'b1;
    @(posedge clk); #1 if_id_write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("stall_req", 32'(imem_req), 0);
      chk("stall_valid", 32'(if_id_valid), 0);
    end
    if_id_write = 1'b1;
    @(posedge clk); #1;
    chk("unstall_valid", 32'(if_id_valid), 1);
    chk("unstall_pc", if_id_pc, 32'h10C);
    chk("unstall_req", 32'(imem_req), 1);
    @(posedge clk); #1 pc_write = 1'b0;
    park();

    // Flush in WAIT, response two cycles later
    expect_fetch(32'h114); expect_fetch(32'h200);
    expect_ifid(32'h200);
    lat = 3;
    @(posedge clk); #1 pc_write = 1'b1;
    @(posedge clk); #1 flush = 1'b1; redirect_pc = 32'h202;
    @(posedge clk); #1 flush = 1'b0; lat = 1;
    chk("flush_valid", 32'(if_id_valid), 0);
    chk("flush_instr", if_id_instr, NOP);
    @(posedge clk);
    @(posedge clk); #1;
    chk("kill_drop", 32'(if_id_valid), 0);
    @(posedge clk); #1 pc_write = 1'b0;
    park();

    // Flush coincident with rvalid
    expect_fetch(32'h204); expect_fetch(32'h300);
    expect_ifid(32'h300);
    @(posedge clk); #1 pc_write = 1'b1;
    @(posedge clk); #1 flush = 1'b1; redirect_pc = 32'h300;
    @(posedge clk); #1 flush = 1'b0;
    chk("flush_rv_drop", 32'(if_id_valid), 0);
    @(posedge clk); #1 pc_write = 1'b0;
    park();

    // Flush coincident with a granted request
    expect_fetch(32'h304); expect_fetch(32'h400);
    expect_ifid(32'h400);
    @(posedge clk); #1 pc_write = 1'b1; flush = 1'b1; redirect_pc = 32'h400;
    @(posedge clk); #1 flush = 1'b0;
    @(posedge clk); #1;
    chk("flush_gnt_drop", 32'(if_id_valid), 0);
    @(posedge clk); #1 pc_write = 1'b0;
    park();

    // Redirect under pc_write=0, then wrap past 0xFFFFFFFC
    expect_fetch(32'hFFFF_FFFC); expect_fetch(32'h0);
    expect_ifid(32'hFFFF_FFFC); expect_ifid(32'h0);
    @(posedge clk); #1 flush = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(posedge clk); #1 flush = 1'b0; pc_write = 1'b1;
    repeat (2) @(posedge clk);
    @(posedge clk); #1 pc_write = 1'b0;
    park();

    // Flush with a full hold buffer and if_id_write=0
    expect_fetch(32'h4); expect_fetch(32'h500);
    expect_ifid(32'h500);
    @(posedge clk); #1 pc_write = 1'b1;
    @(posedge clk); #1 if_id_write = 1'b0;
    @(posedge clk); #1 flush = 1'b1; redirect_pc = 32'h500;
    chk("hold_full_req", 32'(imem_req), 0);
    @(posedge clk); #1 flush = 1'b0; if_id_write = 1'b1;
    chk("hold_flush_valid", 32'(if_id_valid), 0);
    chk("hold_flush_instr", if_id_instr, NOP);
    @(posedge clk); #1 pc_write = 1'b0;
    park();

`ifdef IF_STAGE_PERF_EN
    chk("flush_cnt", flush_cnt, 5);
`endif

    // Reset during WAIT with a stray late response
    expect_fetch(32'h504); expect_fetch(RPC);
    expect_ifid(RPC);
    lat = 2;
    @(posedge clk); #1 pc_write = 1'b1;
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1; lat = 1;
    chk("mid_rst_req", 32'(imem_req), 0);
    chk("mid_rst_valid", 32'(if_id_valid), 0);
    chk("mid_rst_pc", if_id_pc, 0);
    @(posedge clk); #1;
    chk("stray_drop", 32'(if_id_valid), 0);
    @(posedge clk); #1 pc_write = 1'b0;
    park();

    chk("addr_q_empty", 32'(exp_addr.size()), 0);
    chk("ifid_q_empty", 32'(exp_ifid.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
- REQ-001: Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
- REQ-002: clk  input  1  the single clock; all state SHALL update on its rising edge.
- REQ-003: rst_n  input  1  reset, synchronous and active-low.
- REQ-004: pc_write  input  1  from hazard unit; 0 SHALL block PC advance and new requests.
- REQ-005: if_id_write  input  1  from hazard unit; 0 SHALL hold the IF/ID register.
- REQ-006: flush  input  1  taken branch or jump redirect from EX.
- REQ-007: redirect_pc  input  32  redirect target; bits [1:0] SHALL be treated as 00.
- REQ-008: imem_req  output  1  instruction fetch request valid.
- REQ-009: imem_addr  output  32  fetch address; SHALL equal pc while imem_req=1.
- REQ-010: imem_gnt  input  1  request accepted in the same cycle.
- REQ-011: imem_rvalid  input  1  read data valid, at least 1 cycle after grant.
- REQ-012: imem_rdata  input  32  instruction word.
- REQ-013: if_id_pc  output  32  PC of the instruction in IF/ID.
- REQ-014: if_id_instr  output  32  instruction in IF/ID.
- REQ-015: if_id_valid  output  1  IF/ID holds a real instruction.

Function
- REQ-016: FSM states SHALL be IDLE, REQ and WAIT, with at most one fetch outstanding.
- REQ-017: IDLE SHALL move to REQ on the first cycle out of reset.
- REQ-018: In REQ, imem_req SHALL be 1 only when pc_write=1 and the hold buffer is empty.
- REQ-019: On req&gnt: move to WAIT, latch req_pc=pc, and set pc<=pc+4 (mod 2^32, wrap silently).
- REQ-020: In WAIT, on rvalid with if_id_write=1: load IF/ID {req_pc, rdata, valid=1} on that edge (1-cycle latency); go to REQ.
- REQ-021: In WAIT, on rvalid with if_id_write=0: store {req_pc, rdata} in a one-entry hold buffer; go to REQ.
- REQ-022: Hold buffer full and if_id_write=1: IF/ID SHALL load from the buffer, and the buffer SHALL clear.
- REQ-023: if_id_write=0 SHALL freeze if_id_pc, if_id_instr and if_id_valid.
- REQ-024: flush SHALL take priority over pc_write=0 and if_id_write=0.
- REQ-025: flush SHALL set pc<=redirect_pc, set if_id_valid<=0, set if_id_instr<=NOP (32'h0000_0013), and clear the hold buffer.
- REQ-026: flush in WAIT without rvalid SHALL set a kill flag; the next response SHALL then be discarded, kill cleared, and the FSM moves to REQ.
- REQ-027: flush coincident with rvalid SHALL discard that response, leave kill clear, and go to REQ.
- REQ-028: flush coincident with req&gnt SHALL treat the request as killed, with pc<=redirect_pc and not pc+4.
- REQ-029: While if_id_valid=0, if_id_instr SHALL read NOP.

Reset
- REQ-030: While rst_n=0 at an edge: pc=RESET_PC, state=IDLE, imem_req=0, if_id_valid=0, if_id_pc=0, if_id_instr=NOP, hold buffer empty, kill=0.
- REQ-031: Reset mid-WAIT SHALL abandon the outstanding fetch, and its late rvalid SHALL be ignored.

Configuration
- REQ-032: IF_STAGE_PERF_EN defined: add outputs stall_cnt[31:0] and flush_cnt[31:0].
  - stall_cnt SHALL count cycles with pc_write=0.
  - flush_cnt SHALL count flush cycles.
  - Both counters SHALL reset to 0 and wrap.
- REQ-033: IF_STAGE_PERF_EN undefined: neither port nor logic SHALL exist.

Structure
- REQ-034: Package rv_pipe_pkg SHALL hold XLEN=32, the NOP constant and the fetch-state enum.
- REQ-035: The hold buffer SHALL be sub-module if_skid_buf, with one entry plus a full flag.

Verification
- REQ-036: Reset release with RESET_PC=0x100 and imem_rvalid 1 cycle after gnt -> addr 0x100, 0x104 issued; IF/ID valid with pc 0x100 the cycle after the first rvalid.
- REQ-037: if_id_write=0 for 3 cycles as rvalid arrives -> IF/ID frozen, no imem_req; after release IF/ID shows the buffered instruction, and imem_req resumes next cycle.
- REQ-038: flush (redirect 0x200) in WAIT, rvalid 2 cycles later -> response dropped, next imem_addr=0x200, if_id_valid=0, if_id_instr=0x00000013.
- REQ-039: flush and rvalid in the same cycle -> response not loaded, next imem_addr=redirect_pc.
- REQ-040: pc=0xFFFF_FFFC granted -> next imem_addr=0x0000_0000.
- REQ-041: rst_n=0 during WAIT, then a stray rvalid -> IF/ID stays invalid, and fetch restarts at RESET_PC.
